// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_WRAP / MODE_SAT : values of the SATURATE parameter.
//   calc_ext_width()     : width of the intermediate used for count +/- STEP so that the sum
//                          can never truncate.
package param_updown_counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    function automatic int unsigned calc_ext_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count calculator for param_updown_counter.
// Ports:
//   count_i  current count (always within 0..MAX_VAL)
//   up_i     1 = step up, 0 = step down
//   next_o   count after one step, always within 0..MAX_VAL
//   ovf_o    the up-step crosses (or, saturating, clamps onto) MAX_VAL
//   unf_o    the down-step crosses (or, saturating, clamps onto) 0
module updown_next_calc
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 9,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] next_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int unsigned XW = calc_ext_width(WIDTH);

    localparam logic [XW-1:0] MaxX  = XW'(MAX_VAL);
    localparam logic [XW-1:0] StepX = XW'(STEP);
    // MAX_VAL + 1 fits in XW bits because MAX_VAL <= 2**WIDTH - 1.
    localparam logic [XW-1:0] ModX  = XW'(MAX_VAL + 1);

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] up_sum;
    logic [XW-1:0] next_x;

    assign cnt_x  = {1'b0, count_i};
    assign up_sum = cnt_x + StepX;

    always_comb begin
        next_x = cnt_x;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        if (up_i) begin
            if (SATURATE == MODE_SAT) begin
                // Reaching the top rail is the clamp event; it fires once, not while pinned.
                next_x = (up_sum > MaxX) ? MaxX : up_sum;
                ovf_o  = (up_sum >= MaxX) && (cnt_x != MaxX);
            end else if (up_sum <= MaxX) begin
                next_x = up_sum;
            end else begin
                next_x = up_sum - ModX;
                ovf_o  = 1'b1;
            end
        end else begin
            if (SATURATE == MODE_SAT) begin
                next_x = (cnt_x >= StepX) ? (cnt_x - StepX) : '0;
                unf_o  = (cnt_x <= StepX) && (cnt_x != '0);
            end else if (cnt_x >= StepX) begin
                next_x = cnt_x - StepX;
            end else begin
                // cnt_x < STEP <= MAX_VAL, so the sum stays within XW bits and below MAX_VAL+1.
                next_x = cnt_x + ModX - StepX;
                unf_o  = 1'b1;
            end
        end
    end

    assign next_o = next_x[WIDTH-1:0];

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with wrap or saturate mode, parallel load,
// synchronous clear and registered overflow/underflow pulses.
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   clear          synchronous clear to 0 (highest priority)
//   load           synchronous load of min(load_value, MAX_VAL)
//   load_value     value for load
//   enable         count enable, direction from up_down
//   up_down        1 = up, 0 = down
//   count          registered count
//   ovf, unf       registered one-cycle overflow/underflow pulses
//   at_max, at_min count == MAX_VAL / count == 0, combinational from count
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 9,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    if (WIDTH < 2) begin : g_chk_width
        $error("param_updown_counter: WIDTH must be >= 2");
    end
    if ((MAX_VAL >> WIDTH) != 0) begin : g_chk_max
        $error("param_updown_counter: MAX_VAL must be <= 2**WIDTH-1");
    end
    if ((STEP < 1) || (STEP > MAX_VAL)) begin : g_chk_step
        $error("param_updown_counter: STEP must be in 1..MAX_VAL");
    end
    if (SATURATE > MODE_SAT) begin : g_chk_mode
        $error("param_updown_counter: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MaxW = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] calc_next;
    logic             calc_ovf;
    logic             calc_unf;

    updown_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next_calc (
        .count_i (count_q),
        .up_i    (up_down),
        .next_o  (calc_next),
        .ovf_o   (calc_ovf),
        .unf_o   (calc_unf)
    );

    // Priority: clear > load > enable > hold. Pulses default low every cycle.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > MaxW) ? MaxW : load_value;
        end else if (enable) begin
            count_d = calc_next;
            ovf_d   = calc_ovf;
            unf_d   = calc_unf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count  = count_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = (count_q == MaxW);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: three instances share the control inputs
// (wrap/STEP=1, saturate/STEP=1, wrap/STEP=3); each scenario loads a start value and
// checks only the instance it targets.
module tb_param_updown_counter;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic         up_down;

    logic [W-1:0] w_count, s_count, t_count;
    logic         w_ovf, w_unf, w_max, w_min;
    logic         s_ovf, s_unf, s_max, s_min;
    logic         t_ovf, t_unf, t_max, t_min;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .count(w_count), .ovf(w_ovf), .unf(w_unf),
        .at_max(w_max), .at_min(w_min)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .count(s_count), .ovf(s_ovf), .unf(s_unf),
        .at_max(s_max), .at_min(s_min)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(0)) u_step3 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .count(t_count), .ovf(t_ovf), .unf(t_unf),
        .at_max(t_max), .at_min(t_min)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        enable     = 1'b0;
        up_down    = 1'b1;
    endtask

    task automatic load_all(input logic [W-1:0] v);
        idle_inputs();
        load       = 1'b1;
        load_value = v;
        tick();
        load       = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_count", w_count, 0);
        check_eq("rst_ovf", w_ovf, 0);
        check_eq("rst_unf", w_unf, 0);
        check_eq("rst_at_min", w_min, 1);
        check_eq("rst_at_max", w_max, 0);
        reset_n = 1'b1;

        // 1: asynchronous reset while counting at 5.
        load_all(4'd5);
        check_eq("t1_pre", w_count, 5);
        enable = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t1_async_count", w_count, 0);
        check_eq("t1_async_ovf", w_ovf, 0);
        tick();
        tick();
        check_eq("t1_held_count", w_count, 0);
        check_eq("t1_held_unf", w_unf, 0);
        enable  = 1'b0;
        reset_n = 1'b1;
        tick();
        check_eq("t1_after", w_count, 0);

        // 2: wrap up 0..9..0, then down 0 -> 9.
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq($sformatf("t2_up_count%0d", i), w_count, i % 10);
            check_eq($sformatf("t2_up_ovf%0d", i), w_ovf, (i == 10) ? 1 : 0);
            check_eq($sformatf("t2_up_max%0d", i), w_max, (i == 9) ? 1 : 0);
        end
        up_down = 1'b0;
        tick();
        check_eq("t2_dn_count", w_count, 9);
        check_eq("t2_dn_unf", w_unf, 1);
        enable = 1'b0;
        tick();
        check_eq("t2_hold_count", w_count, 9);
        check_eq("t2_hold_unf", w_unf, 0);

        // 3: saturating up from 7 and down from 1.
        load_all(4'd7);
        check_eq("t3_load", s_count, 7);
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("t3_up_count%0d", i), s_count, (i == 0) ? 8 : 9);
            check_eq($sformatf("t3_up_ovf%0d", i), s_ovf, (i == 1) ? 1 : 0);
        end
        load_all(4'd1);
        check_eq("t3_load1", s_count, 1);
        enable  = 1'b1;
        up_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t3_dn_count%0d", i), s_count, 0);
            check_eq($sformatf("t3_dn_unf%0d", i), s_unf, (i == 0) ? 1 : 0);
            check_eq($sformatf("t3_dn_min%0d", i), s_min, 1);
        end

        // 4: load clamp and priority.
        load_all(4'd12);
        check_eq("t4_clamp", w_count, 9);
        check_eq("t4_clamp_max", w_max, 1);
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 4'd3;
        tick();
        check_eq("t4_clear_over_load", w_count, 0);
        clear   = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        tick();
        check_eq("t4_load_over_en", w_count, 3);
        check_eq("t4_load_ovf", w_ovf, 0);

        // 5: STEP=3 wrap in both directions.
        load_all(4'd8);
        check_eq("t5_load", t_count, 8);
        enable  = 1'b1;
        up_down = 1'b1;
        tick();
        check_eq("t5_up_count", t_count, 1);
        check_eq("t5_up_ovf", t_ovf, 1);
        up_down = 1'b0;
        tick();
        check_eq("t5_dn_count", t_count, 8);
        check_eq("t5_dn_unf", t_unf, 1);
        check_eq("t5_dn_ovf", t_ovf, 0);

        // 6: direction toggling every cycle, then hold.
        load_all(4'd4);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check_eq($sformatf("t6_count%0d", i), w_count, (i % 2 == 0) ? 5 : 4);
            check_eq($sformatf("t6_pulse%0d", i), {w_ovf, w_unf}, 0);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            up_down = 1'b1;
            tick();
            check_eq($sformatf("t6_hold%0d", i), w_count, 4);
            check_eq($sformatf("t6_hold_pulse%0d", i), {w_ovf, w_unf}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
